// File: rtl/ec1_datapath.sv
// ec1_datapath: PC/IR/accumulator datapath of an EC-1 style processor, steered by an external control unit.
// Holds a 32x8 unified memory with an asynchronous read port and a preload port for loading programs.
module ec1_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [1:0]        Halt,
  input  logic [DATA_W-1:0] Input,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  output logic [2:0]        IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] Output,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned OP_W  = 3;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] mdata;
  logic [DATA_W-1:0] alu;
  logic              halted_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Address, ALU, A-mux and PC-source selection; all from pre-edge register values.
  always_comb begin
    maddr   = Meminst ? pc_q : ir_q[ADDR_W-1:0];
    mdata   = mem[maddr];
    alu     = Sub ? (a_q - mdata) : (a_q + mdata);
    pc_next = JMPmux ? ir_q[ADDR_W-1:0] : (pc_q + ADDR_W'(1));
    a_next  = '0;
    unique case (Asel)
      2'b00:   a_next = alu;
      2'b01:   a_next = Input;
      2'b10:   a_next = mdata;
      default: a_next = '0;
    endcase
  end

  // Architectural registers; frozen once halted, halt flag sticky until reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      halted_q <= 1'b0;
    end else begin
      if (!halted_q) begin
        if (IRload) ir_q <= mdata;
        if (PCload) pc_q <= pc_next;
        if (Aload)  a_q  <= a_next;
      end
      if (|Halt) halted_q <= 1'b1;
    end
  end

  // Preload always wins; a CU write is dropped under reset, halt or a colliding preload.
  always_ff @(posedge Clock) begin
    if (LdEn) begin
      mem[LdAddr] <= LdData;
    end else if (MemWr && !Reset && !halted_q) begin
      mem[maddr] <= a_q;
    end
  end

  assign IR     = ir_q[DATA_W-1 -: OP_W];
  assign Aeq0   = (a_q == '0);
  assign Apos   = ~a_q[DATA_W-1];
  assign Output = a_q;
  assign PC     = pc_q;
  assign Halted = halted_q;

endmodule

// File: tb/tb_ec1_datapath.sv
// tb_ec1_datapath: directed scenarios plus random control words, checked by a scoreboard fed
// from an arithmetic reference model of the datapath.
module tb_ec1_datapath;

  logic       Clock = 1'b0;
  logic       Reset, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, LdEn;
  logic [1:0] Asel, Halt;
  logic [7:0] Input, LdData;
  logic [4:0] LdAddr;
  logic [2:0] IR;
  logic       Aeq0, Apos, Halted;
  logic [7:0] Output;
  logic [4:0] PC;

  ec1_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt),
    .Input(Input), .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
    .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Output(Output), .PC(PC), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       rst, irload, jmpmux, pcload, meminst, memwr, aload, sub, lden;
    logic [1:0] asel, halt;
    logic [7:0] inp, lddata;
    logic [4:0] ldaddr;
  } ctl_t;

  typedef struct {
    logic [4:0] pc;
    logic [2:0] ir;
    logic [7:0] out;
    logic       aeq0, apos, halted;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state as plain integers
  int m_pc, m_ir, m_a, m_halt;
  int m_mem[32];

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Drive one control word, advance the model by one clock, queue the expected outputs.
  task automatic apply(input ctl_t c);
    int maddr, md, npc, nir, na, nh;
    exp_t e;
    Reset = c.rst; IRload = c.irload; JMPmux = c.jmpmux; PCload = c.pcload;
    Meminst = c.meminst; MemWr = c.memwr; Aload = c.aload; Sub = c.sub; LdEn = c.lden;
    Asel = c.asel; Halt = c.halt; Input = c.inp; LdData = c.lddata; LdAddr = c.ldaddr;
    maddr = c.meminst ? m_pc : (m_ir % 32);
    md = m_mem[maddr];
    npc = m_pc; nir = m_ir; na = m_a; nh = m_halt;
    if (c.rst) begin
      npc = 0; nir = 0; na = 0; nh = 0;
    end else begin
      if (m_halt == 0) begin
        if (c.irload) nir = md;
        if (c.pcload) npc = c.jmpmux ? (m_ir % 32) : ((m_pc + 1) % 32);
        if (c.aload) begin
          case (c.asel)
            2'd0:    na = c.sub ? ((m_a - md + 256) % 256) : ((m_a + md) % 256);
            2'd1:    na = int'(c.inp);
            2'd2:    na = md;
            default: na = 0;
          endcase
        end
        if (c.memwr && !c.lden) m_mem[maddr] = m_a;
      end
      if (c.halt != 2'b00) nh = 1;
    end
    if (c.lden) m_mem[c.ldaddr] = int'(c.lddata);
    m_pc = npc; m_ir = nir; m_a = na; m_halt = nh;
    e.pc = 5'(npc); e.ir = 3'(nir / 32); e.out = 8'(na);
    e.aeq0 = (na == 0); e.apos = (na < 128); e.halted = (nh != 0);
    sb.push_back(e);
    @(negedge Clock);
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    ctl_t c;
    c = idle(); c.lden = 1'b1; c.ldaddr = a; c.lddata = d;
    apply(c);
  endtask

  // Places v in IR by writing it at the current PC and fetching without advancing.
  task automatic set_ir(input logic [7:0] v);
    ctl_t c;
    preload(5'(m_pc), v);
    c = idle(); c.irload = 1'b1; c.meminst = 1'b1;
    apply(c);
  endtask

  task automatic load_in(input logic [7:0] v);
    ctl_t c;
    c = idle(); c.aload = 1'b1; c.asel = 2'b01; c.inp = v;
    apply(c);
  endtask

  task automatic a_from_operand(input logic sub_op, input logic [1:0] sel);
    ctl_t c;
    c = idle(); c.aload = 1'b1; c.asel = sel; c.sub = sub_op;
    apply(c);
  endtask

  // Monitor: registered outputs are compared once per clock against the queued expectation.
  always @(posedge Clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if ({PC, IR, Output, Aeq0, Apos, Halted} !==
          {mon_e.pc, mon_e.ir, mon_e.out, mon_e.aeq0, mon_e.apos, mon_e.halted}) begin
        n_fail++;
        $display("FAIL sb_cycle t=%0t: got pc=%0h ir=%0h out=%0h z=%b p=%b h=%b, want pc=%0h ir=%0h out=%0h z=%b p=%b h=%b",
                 $time, PC, IR, Output, Aeq0, Apos, Halted,
                 mon_e.pc, mon_e.ir, mon_e.out, mon_e.aeq0, mon_e.apos, mon_e.halted);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t c;
    m_pc = 0; m_ir = 0; m_a = 0; m_halt = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    c = idle();
    Reset = 1'b1; IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0; Aload = 0;
    Sub = 0; LdEn = 0; Asel = 0; Halt = 0; Input = 0; LdData = 0; LdAddr = 0;
    @(negedge Clock);

    // 1: preload every word while in reset, disturb state, then reset again
    for (int i = 0; i < 32; i++) begin
      c = idle(); c.rst = 1'b1; c.lden = 1'b1; c.ldaddr = 5'(i);
      c.lddata = (i == 3) ? 8'h5A : 8'($urandom);
      apply(c);
    end
    load_in(8'h9C);
    c = idle(); c.irload = 1'b1; c.pcload = 1'b1; c.meminst = 1'b1;
    apply(c);
    apply(c);
    c = idle(); c.rst = 1'b1; c.aload = 1'b1; c.asel = 2'b01; c.inp = 8'h77; c.pcload = 1'b1;
    apply(c);
    apply(c);
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_ir", 32'(IR), 32'h0);
    chk("rst_out", 32'(Output), 32'h0);
    chk("rst_aeq0", 32'(Aeq0), 32'h1);
    chk("rst_apos", 32'(Apos), 32'h1);
    chk("rst_halted", 32'(Halted), 32'h0);
    set_ir(8'h03);
    a_from_operand(1'b0, 2'b10);
    chk("mem3_kept", 32'(Output), 32'h5A);

    // 2: fetch with increment, then wrap
    preload(5'd0, 8'hA7);
    c = idle(); c.irload = 1'b1; c.pcload = 1'b1; c.meminst = 1'b1;
    apply(c);
    chk("fetch_ir", 32'(IR), 32'h5);
    chk("fetch_pc", 32'(PC), 32'h1);
    c = idle(); c.pcload = 1'b1;
    for (int i = 0; i < 31; i++) apply(c);
    chk("pc_wrap", 32'(PC), 32'h0);

    // 3: load, add, subtract, zero wrap
    preload(5'd7, 8'h05);
    load_in(8'h03);
    chk("load_in", 32'(Output), 32'h03);
    set_ir(8'h07);
    a_from_operand(1'b0, 2'b00);
    chk("add", 32'(Output), 32'h08);
    a_from_operand(1'b1, 2'b00);
    a_from_operand(1'b1, 2'b00);
    chk("sub_neg", 32'(Output), 32'hFE);
    chk("sub_apos", 32'(Apos), 32'h0);
    chk("sub_aeq0", 32'(Aeq0), 32'h0);
    load_in(8'hFF);
    preload(5'd7, 8'h01);
    a_from_operand(1'b0, 2'b00);
    chk("add_wrap", 32'(Output), 32'h00);
    chk("add_wrap_z", 32'(Aeq0), 32'h1);

    // 4: store of old A alongside a clear, then preload beating a store
    load_in(8'h42);
    set_ir(8'h09);
    c = idle(); c.memwr = 1'b1; c.aload = 1'b1; c.asel = 2'b11;
    apply(c);
    chk("clear_a", 32'(Output), 32'h00);
    a_from_operand(1'b0, 2'b10);
    chk("store_old_a", 32'(Output), 32'h42);
    c = idle(); c.memwr = 1'b1; c.lden = 1'b1; c.ldaddr = 5'd9; c.lddata = 8'h11;
    apply(c);
    a_from_operand(1'b0, 2'b10);
    chk("preload_wins", 32'(Output), 32'h11);

    // 5: jump, and jump with a simultaneous fetch uses the old operand
    set_ir(8'hD4);
    c = idle(); c.pcload = 1'b1; c.jmpmux = 1'b1;
    apply(c);
    chk("jump_pc", 32'(PC), 32'h14);
    preload(5'h14, 8'h00);
    c = idle(); c.pcload = 1'b1; c.jmpmux = 1'b1; c.irload = 1'b1; c.meminst = 1'b1;
    apply(c);
    chk("jump_fetch_pc", 32'(PC), 32'h14);
    chk("jump_fetch_ir", 32'(IR), 32'h0);

    // 6: halt freezes everything the CU drives
    c = idle(); c.halt = 2'b01;
    apply(c);
    for (int i = 0; i < 10; i++) begin
      c = idle(); c.pcload = 1'b1; c.aload = 1'b1; c.memwr = 1'b1; c.irload = 1'b1;
      c.asel = 2'b01; c.inp = 8'($urandom); c.meminst = 1'($urandom);
      c.meminst = 1'b0;
      apply(c);
    end
    chk("halt_pc", 32'(PC), 32'h14);
    chk("halt_out", 32'(Output), 32'h11);
    chk("halt_ir", 32'(IR), 32'h0);
    chk("halt_flag", 32'(Halted), 32'h1);
    c = idle(); c.rst = 1'b1;
    apply(c);
    chk("halt_cleared", 32'(Halted), 32'h0);
    a_from_operand(1'b0, 2'b10);
    chk("halt_mem_kept", 32'(Output), 32'hD4);

    // Random control words against the model
    for (int i = 0; i < 400; i++) begin
      c = ctl_t'({$urandom, $urandom});
      c.rst  = (($urandom % 40) == 0);
      c.halt = (($urandom % 25) == 0) ? 2'(($urandom % 3) + 1) : 2'b00;
      c.lden = (($urandom % 4) == 0);
      apply(c);
    end

    @(negedge Clock);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ec1_datapath.md
Name: ec1_datapath

Overview:
Datapath half of the EC-1 style processor. It sits opposite the control unit (CU) and responds to the CU's control word (IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt). It returns the opcode and status flags (IR, Aeq0, Apos) that the CU consumes. It contains PC, IR, accumulator A, a 32x8 unified memory, an add/sub unit and the Asel mux, plus a preload port so benches can load programs.

Parameters:
DATA_W, 8, accumulator/memory/IO data width
ADDR_W, 5, PC and operand address width (memory depth = 2**ADDR_W = 32)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
IRload  input  1  load instruction register from memory data
JMPmux  input  1  PC source select: 1 = IR operand, 0 = PC+1
PCload  input  1  load PC
Meminst  input  1  memory address select: 1 = PC, 0 = IR operand
MemWr  input  1  write A into memory at selected address
Asel  input  2  A input mux select
Aload  input  1  load accumulator
Sub  input  1  ALU op: 1 = A - M, 0 = A + M
Halt  input  2  halt request; asserted when either bit is 1
Input  input  DATA_W  external data input
LdEn  input  1  bench preload write enable
LdAddr  input  ADDR_W  preload address
LdData  input  DATA_W  preload data
IR  output  3  opcode field IRreg[7:5] to CU
Aeq0  output  1  A == 0
Apos  output  1  A[7] == 0 (zero counts as positive)
Output  output  DATA_W  current A value
PC  output  ADDR_W  current program counter (observation)
Halted  output  1  sticky halted flag

Behaviour:
- Reset (synchronous, rising edge with Reset = 1):
  - PC = 0, IRreg = 8'h00, A = 8'h00, Halted = 0.
  - Results: IR = 3'b000, Aeq0 = 1, Apos = 1, Output = 0.
  - Memory contents are not cleared.
  - Control inputs are ignored while Reset = 1.
  - Reset mid-program aborts immediately; no pending write completes.
- Memory address:
  - maddr = Meminst ? PC : IRreg[4:0].
  - Read is asynchronous: mdata = mem[maddr].
  - Write is synchronous: when MemWr = 1, mem[maddr] <= A (old A).
- Preload:
  - When LdEn = 1, mem[LdAddr] <= LdData.
  - Preload is honoured even during Reset or Halted.
  - LdEn has priority over MemWr in the same cycle; the MemWr write is dropped.
- IR: when IRload = 1, IRreg <= mdata. The opcode is IRreg[7:5]; the operand is IRreg[4:0].
- PC:
  - When PCload = 1, PC <= JMPmux ? IRreg[4:0] (old IRreg) : PC + 1.
  - Increment wraps 31 -> 0.
- ALU:
  - alu = Sub ? A - mdata : A + mdata, truncated modulo 2**DATA_W.
  - No carry or overflow output.
- A mux:
  - 00 = alu, 01 = Input, 10 = mdata, 11 = 8'h00.
  - When Aload = 1, A <= mux.
- Same-cycle events: all registers sample pre-edge values.
  - IRload + PCload: IR gets mem[old PC], PC advances.
  - Aload + MemWr: memory receives old A.
- Flags and data outputs: Aeq0, Apos and Output are combinational from the A register. They are valid the cycle after an Aload.
- Halt:
  - Halt != 0 at an edge sets Halted = 1.
  - Halted is sticky until Reset.
  - While Halted = 1, PC, IRreg, A and CU-driven memory writes are frozen regardless of the control inputs.
  - Updates in the cycle where Halt first asserts still occur.
- Latency: every register update takes one clock; there is no pipelining.

Test Plan:
1. Reset and flags: hold Reset for 2 cycles after arbitrary loads -> PC = 0, IR = 000, Output = 0, Aeq0 = 1, Apos = 1, Halted = 0; preloaded mem[3] = 8'h5A is unchanged.
2. Fetch and increment: preload mem[0] = 8'hA7, pulse IRload + PCload (JMPmux = 0, Meminst = 1) -> IR = 3'b101, PC = 1; apply 31 further increments -> PC wraps to 0.
3. Load, add and subtract:
   - Preload mem[7] = 8'h05; Input = 8'h03, Asel = 01, Aload -> A = 3.
   - Meminst = 0 with IRreg operand 7, Asel = 00, Sub = 0 -> A = 8; Sub = 1 twice -> A = 8'hFE, Apos = 0, Aeq0 = 0.
   - A = 8'hFF + 8'h01 -> 8'h00, Aeq0 = 1.
4. Store and collision: A = 8'h42 with MemWr to operand 9 and Aload (Asel = 11) in the same cycle -> mem[9] = 8'h42, A = 0. Then LdEn to address 9 with data 8'h11 together with MemWr -> mem[9] = 8'h11.
5. Jump: IRreg = 8'hD4, PCload + JMPmux = 1 -> PC = 5'h14. Simultaneous IRload with mem[PC] = 8'h00 -> PC still 5'h14 (old IR used).
6. Halt: Halt = 2'b01 for one cycle, then drive PCload, Aload and MemWr every cycle for 10 cycles -> PC, A, IR and memory unchanged, Halted = 1. Then Reset -> Halted = 0.
